// File: rtl/cr_iu_pkg.sv
// cr_iu_pkg: shared types and constants for the IU execution-stage controllers.
//   ex_state_e   - 2-bit EX slot FSM encoding
//   EXPT_*       - exception vector codes
//   PRIV_*       - privilege mode encodings
//   expt_cause_t - raw exception causes from decode
package cr_iu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    EXPT = 2'd3
  } ex_state_e;

  localparam logic [4:0] EXPT_ACC     = 5'd1;
  localparam logic [4:0] EXPT_INV     = 5'd2;
  localparam logic [4:0] EXPT_BKPT    = 5'd3;
  localparam logic [4:0] EXPT_ECALL_U = 5'd8;
  localparam logic [4:0] EXPT_ECALL_S = 5'd9;
  localparam logic [4:0] EXPT_NONE    = 5'd10;
  localparam logic [4:0] EXPT_ECALL_M = 5'd11;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic acc;
    logic inv;
    logic bkpt;
    logic ecall;
  } expt_cause_t;

endpackage

// File: rtl/cr_iu_ex_ctrl_pipe_if.sv
// cr_iu_ex_ctrl_pipe_if: decode-side handshake, unit select/done and
// retire/exception signals of the EX slot controller.
//   master - decode/units/CP0 side (drives dec_*, wb_stall, flush, unit_done)
//   slave  - the EX controller
interface cr_iu_ex_ctrl_pipe_if #(
  parameter int UNIT_NUM = 6,
  parameter int VEC_W    = 5
);
  logic                dec_vld;
  logic                dec_ready;
  logic [UNIT_NUM-1:0] dec_unit_onehot;
  logic                dec_rand;
  logic                dec_ni;
  logic                dec_expt_acc;
  logic                dec_expt_inv;
  logic                dec_expt_bkpt;
  logic                dec_expt_ecall;
  logic [1:0]          cp0_yy_priv_mode;
  logic                wb_stall;
  logic                flush;
  logic [UNIT_NUM-1:0] unit_done;
  logic [UNIT_NUM-1:0] ex_unit_sel;
  logic [UNIT_NUM-1:0] ex_data_sel;
  logic                ex_stall;
  logic                retire_vld;
  logic                retire_ni;
  logic                expt_vld;
  logic [VEC_W-1:0]    expt_vec;
  logic                stall_timeout;

  modport master (
    output dec_vld, dec_unit_onehot, dec_rand, dec_ni, dec_expt_acc, dec_expt_inv,
           dec_expt_bkpt, dec_expt_ecall, cp0_yy_priv_mode, wb_stall, flush, unit_done,
    input  dec_ready, ex_unit_sel, ex_data_sel, ex_stall, retire_vld, retire_ni,
           expt_vld, expt_vec, stall_timeout
  );

  modport slave (
    input  dec_vld, dec_unit_onehot, dec_rand, dec_ni, dec_expt_acc, dec_expt_inv,
           dec_expt_bkpt, dec_expt_ecall, cp0_yy_priv_mode, wb_stall, flush, unit_done,
    output dec_ready, ex_unit_sel, ex_data_sel, ex_stall, retire_vld, retire_ni,
           expt_vld, expt_vec, stall_timeout
  );
endinterface

// File: rtl/cr_iu_expt_prio.sv
// cr_iu_expt_prio: combinational exception cause -> vector encoder.
//   cause_i - raw causes, priv_i - privilege mode (selects ecall flavour)
//   vec_o   - highest-priority vector (EXPT_NONE when no cause)
//   any_o   - at least one cause present
module cr_iu_expt_prio import cr_iu_pkg::*; #(
  parameter int VEC_W = 5
) (
  input  expt_cause_t      cause_i,
  input  logic [1:0]       priv_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             any_o
);
  always_comb begin
    vec_o = VEC_W'(EXPT_NONE);
    if (cause_i.acc)       vec_o = VEC_W'(EXPT_ACC);
    else if (cause_i.inv)  vec_o = VEC_W'(EXPT_INV);
    else if (cause_i.bkpt) vec_o = VEC_W'(EXPT_BKPT);
    else if (cause_i.ecall) begin
      // Reserved mode 2'b10 is treated like M.
      case (priv_i)
        PRIV_U:  vec_o = VEC_W'(EXPT_ECALL_U);
        PRIV_S:  vec_o = VEC_W'(EXPT_ECALL_S);
        default: vec_o = VEC_W'(EXPT_ECALL_M);
      endcase
    end
  end

  assign any_o = |cause_i;
endmodule

// File: rtl/cr_iu_ex_ctrl_pipe.sv
// cr_iu_ex_ctrl_pipe: single-slot EX controller. Accepts one decoded
// instruction, selects its execution unit, waits for that unit's done,
// retires it (or emits its exception) and flags long stalls.
//   forever_cpuclk - clock, cpurst - synchronous active-high reset
//   ex_if          - decode handshake, unit select/done, retire/exception outputs
module cr_iu_ex_ctrl_pipe import cr_iu_pkg::*; #(
  parameter int UNIT_NUM    = 6,
  parameter int STALL_LIMIT = 255,
  parameter int VEC_W       = 5
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst,
  cr_iu_ex_ctrl_pipe_if.slave  ex_if
);
  localparam int               CNT_W  = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(STALL_LIMIT - 1);

  ex_state_e           state_q, state_d;
  logic [UNIT_NUM-1:0] unit_q, unit_d;
  logic                rand_q, rand_d, ni_q, ni_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  expt_cause_t         dec_cause;
  logic [VEC_W-1:0]    dec_vec;
  logic                dec_expt;
  logic                busy, done_hit, retire, live, accept, wait_miss;

  assign dec_cause = '{acc: ex_if.dec_expt_acc, inv: ex_if.dec_expt_inv,
                       bkpt: ex_if.dec_expt_bkpt, ecall: ex_if.dec_expt_ecall};

  cr_iu_expt_prio #(.VEC_W(VEC_W)) u_prio (
    .cause_i (dec_cause),
    .priv_i  (ex_if.cp0_yy_priv_mode),
    .vec_o   (dec_vec),
    .any_o   (dec_expt)
  );

  assign busy      = (state_q == EXEC) || (state_q == WAIT);
  // Only the slot's own unit can complete it; other units' done is ignored.
  assign done_hit  = |(ex_if.unit_done & unit_q);
  // Random instructions have no unit to wait for and retire out of EXEC.
  assign retire    = ((state_q == EXEC) && rand_q) || (busy && done_hit);
  // Pulses and handshakes are masked by flush and by reset.
  assign live      = !cpurst && !ex_if.flush;
  assign wait_miss = (state_q == WAIT) && !done_hit;

  assign ex_if.dec_ready     = live && !ex_if.wb_stall && ((state_q == IDLE) || retire);
  assign accept              = ex_if.dec_vld && ex_if.dec_ready;
  assign ex_if.retire_vld    = retire && live;
  assign ex_if.retire_ni     = retire && live && ni_q;
  assign ex_if.ex_unit_sel   = ((state_q == EXEC) && !rand_q && live) ? unit_q : '0;
  assign ex_if.ex_data_sel   = (busy && !rand_q && !cpurst) ? unit_q : '0;
  assign ex_if.ex_stall      = !cpurst && ((busy && !ex_if.retire_vld) || (state_q == EXPT));
  assign ex_if.expt_vld      = (state_q == EXPT) && live;
  assign ex_if.expt_vec      = vec_q;
  // Fires only on the step into the limit; the saturated counter stays quiet.
  assign ex_if.stall_timeout = live && wait_miss && (cnt_q == CNT_TO);

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    rand_d  = rand_q;
    ni_d    = ni_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;

    case (state_q)
      EXEC:    if (!retire) state_d = WAIT;
      EXPT:    state_d = IDLE;
      default: ;
    endcase
    if (retire) state_d = IDLE;

    // Accept only happens from IDLE or on a retire cycle, so it overrides.
    if (accept) begin
      state_d = dec_expt ? EXPT : EXEC;
      unit_d  = ex_if.dec_unit_onehot;
      rand_d  = ex_if.dec_rand;
      ni_d    = ex_if.dec_ni;
      vec_d   = dec_vec;
    end

    if (wait_miss && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    if (retire || ex_if.flush)           cnt_d = '0;
    if (ex_if.flush)                     state_d = IDLE;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= IDLE;
      unit_q  <= '0;
      rand_q  <= 1'b0;
      ni_q    <= 1'b0;
      vec_q   <= VEC_W'(EXPT_NONE);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      rand_q  <= rand_d;
      ni_q    <= ni_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cr_iu_ex_ctrl_pipe.sv
// tb_cr_iu_ex_ctrl_pipe: table of per-cycle {inputs, expected outputs} rows,
// followed by hand-written stall-timeout, flush and reset sequences.
module tb_cr_iu_ex_ctrl_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cr_iu_ex_ctrl_pipe_if #(.UNIT_NUM(6), .VEC_W(5)) ifc ();

  cr_iu_ex_ctrl_pipe #(.UNIT_NUM(6), .STALL_LIMIT(4), .VEC_W(5)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .ex_if          (ifc)
  );

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  typedef struct packed {
    logic       rdy;
    logic [5:0] usel;
    logic [5:0] dsel;
    logic       stall;
    logic       ret;
    logic       rni;
    logic       xv;
    logic [4:0] xvec;
    logic       to;
  } out_t;

  typedef struct {
    logic       vld;
    logic [5:0] unit;
    logic       rnd;
    logic       ni;
    logic [3:0] cause;  // {acc, inv, bkpt, ecall}
    logic [1:0] priv;
    logic       wb;
    logic       fl;
    logic [5:0] done;
    out_t       exp;
  } row_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  row_t tbl[34];

  function automatic out_t mk_o(input logic rdy, input logic [5:0] usel, input logic [5:0] dsel,
                                input logic stall, input logic ret, input logic rni, input logic xv,
                                input logic [4:0] xvec, input logic to);
    out_t v;
    v.rdy = rdy; v.usel = usel; v.dsel = dsel; v.stall = stall; v.ret = ret;
    v.rni = rni; v.xv = xv; v.xvec = xvec; v.to = to;
    return v;
  endfunction

  function automatic out_t idle_o(input logic [4:0] xvec);
    return mk_o(T, 6'b0, 6'b0, F, F, F, F, xvec, F);
  endfunction

  function automatic row_t mk_r(input logic vld, input logic [5:0] unit, input logic rnd, input logic ni,
                                input logic [3:0] cause, input logic [1:0] priv, input logic wb,
                                input logic fl, input logic [5:0] done, input out_t e);
    row_t x;
    x.vld = vld; x.unit = unit; x.rnd = rnd; x.ni = ni; x.cause = cause; x.priv = priv;
    x.wb = wb; x.fl = fl; x.done = done; x.exp = e;
    return x;
  endfunction

  task automatic drive(input row_t x);
    ifc.dec_vld          = x.vld;
    ifc.dec_unit_onehot  = x.unit;
    ifc.dec_rand         = x.rnd;
    ifc.dec_ni           = x.ni;
    ifc.dec_expt_acc     = x.cause[3];
    ifc.dec_expt_inv     = x.cause[2];
    ifc.dec_expt_bkpt    = x.cause[1];
    ifc.dec_expt_ecall   = x.cause[0];
    ifc.cp0_yy_priv_mode = x.priv;
    ifc.wb_stall         = x.wb;
    ifc.flush            = x.fl;
    ifc.unit_done        = x.done;
  endtask

  task automatic din(input logic vld, input logic [5:0] unit, input logic [3:0] cause,
                     input logic fl, input logic [5:0] done);
    drive(mk_r(vld, unit, F, F, cause, 2'b00, F, fl, done, '0));
  endtask

  function automatic out_t samp();
    return mk_o(ifc.dec_ready, ifc.ex_unit_sel, ifc.ex_data_sel, ifc.ex_stall, ifc.retire_vld,
                ifc.retire_ni, ifc.expt_vld, ifc.expt_vec, ifc.stall_timeout);
  endfunction

  task automatic chk_out(input string nm, input out_t e);
    out_t a;
    a = samp();
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got rdy=%b usel=%b dsel=%b stall=%b ret=%b rni=%b xv=%b xvec=%0d to=%b | want rdy=%b usel=%b dsel=%b stall=%b ret=%b rni=%b xv=%b xvec=%0d to=%b",
                  nm, a.rdy, a.usel, a.dsel, a.stall, a.ret, a.rni, a.xv, a.xvec, a.to,
                  e.rdy, e.usel, e.dsel, e.stall, e.ret, e.rni, e.xv, e.xvec, e.to);
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    // Unit 0 with done tied high: four back-to-back accepts and retires.
    tbl[0]  = mk_r(T, 6'b000001, F, F, 4'b0000, 2'b00, F, F, 6'h3f, idle_o(5'd10));
    tbl[1]  = mk_r(T, 6'b000001, F, F, 4'b0000, 2'b00, F, F, 6'h3f, mk_o(T, 6'b000001, 6'b000001, F, T, F, F, 5'd10, F));
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = mk_r(F, 6'b000001, F, F, 4'b0000, 2'b00, F, F, 6'h3f, mk_o(T, 6'b000001, 6'b000001, F, T, F, F, 5'd10, F));
    tbl[5]  = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd10));
    // Unit 3 done after 5 cycles; unit 0 done in between is ignored.
    tbl[6]  = mk_r(T, 6'b001000, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd10));
    tbl[7]  = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(F, 6'b001000, 6'b001000, T, F, F, F, 5'd10, F));
    tbl[8]  = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'b000001, mk_o(F, 6'b0, 6'b001000, T, F, F, F, 5'd10, F));
    tbl[9]  = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b001000, T, F, F, F, 5'd10, F));
    tbl[10] = tbl[9];
    tbl[11] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'b001000, mk_o(T, 6'b0, 6'b001000, F, T, F, F, 5'd10, F));
    // Exceptions: bkpt beats ecall; ecall by privilege; acc beats inv; inv beats bkpt.
    tbl[12] = mk_r(T, 6'b000100, F, F, 4'b0011, 2'b11, F, F, 6'h00, idle_o(5'd10));
    tbl[13] = mk_r(T, 6'b000001, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd3, F));
    tbl[14] = mk_r(T, 6'b000001, F, F, 4'b0001, 2'b00, F, F, 6'h00, idle_o(5'd3));
    tbl[15] = mk_r(T, 6'b000001, F, F, 4'b0001, 2'b01, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd8, F));
    tbl[16] = mk_r(T, 6'b000001, F, F, 4'b0001, 2'b01, F, F, 6'h00, idle_o(5'd8));
    tbl[17] = mk_r(T, 6'b000001, F, F, 4'b1100, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd9, F));
    tbl[18] = mk_r(T, 6'b000001, F, F, 4'b1100, 2'b00, F, F, 6'h00, idle_o(5'd9));
    tbl[19] = mk_r(T, 6'b000001, F, F, 4'b0110, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd1, F));
    tbl[20] = mk_r(T, 6'b000001, F, F, 4'b0110, 2'b00, F, F, 6'h00, idle_o(5'd1));
    tbl[21] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd2, F));
    tbl[22] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd2));
    // wb_stall blocks accept, including on a retire cycle; NI retire.
    tbl[23] = mk_r(T, 6'b000001, F, F, 4'b0000, 2'b00, T, F, 6'h00, mk_o(F, 6'b0, 6'b0, F, F, F, F, 5'd2, F));
    tbl[24] = mk_r(T, 6'b000010, F, T, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd2));
    tbl[25] = mk_r(T, 6'b000001, F, F, 4'b0000, 2'b00, T, F, 6'b000010, mk_o(F, 6'b000010, 6'b000010, F, T, T, F, 5'd10, F));
    tbl[26] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd10));
    // Random NI instruction: no unit select, retires at t+1.
    tbl[27] = mk_r(T, 6'b000000, T, T, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd10));
    tbl[28] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(T, 6'b0, 6'b0, F, T, T, F, 5'd10, F));
    tbl[29] = tbl[26];
    // Exception accepted on a retire cycle.
    tbl[30] = mk_r(T, 6'b000100, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd10));
    tbl[31] = mk_r(T, 6'b000001, F, F, 4'b1000, 2'b00, F, F, 6'b000100, mk_o(T, 6'b000100, 6'b000100, F, T, F, F, 5'd10, F));
    tbl[32] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, mk_o(F, 6'b0, 6'b0, T, F, F, T, 5'd1, F));
    tbl[33] = mk_r(F, 6'b000000, F, F, 4'b0000, 2'b00, F, F, 6'h00, idle_o(5'd1));

    din(F, 6'b0, 4'b0, F, 6'b0);
    repeat (2) @(negedge clk);
    #1 chk_out("reset", mk_o(F, 6'b0, 6'b0, F, F, F, F, 5'd10, F));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i]);
      #1 chk_out($sformatf("row%0d", i), tbl[i].exp);
      @(negedge clk);
    end

    // Stall timeout: single pulse on the 4th WAIT cycle, then saturate.
    din(T, 6'b010000, 4'b0, F, 6'b0); #1; @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b0);
    #1 chkv("to_exec_stall", ifc.ex_stall, 1);
    @(negedge clk);
    for (int w = 1; w <= 6; w++) begin
      #1 chkv($sformatf("to_wait%0d", w), ifc.stall_timeout, (w == 4) ? 1 : 0);
      @(negedge clk);
    end
    din(T, 6'b000001, 4'b0, T, 6'b010000);
    #1 chkv("to_flush_ret", ifc.retire_vld, 0);
    chkv("to_flush_rdy", ifc.dec_ready, 0);
    @(negedge clk);
    // Counter was cleared by the flush: timeout fires again after 4 WAITs.
    din(T, 6'b010000, 4'b0, F, 6'b0);
    #1 chkv("to_idle_rdy", ifc.dec_ready, 1);
    @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b0); #1; @(negedge clk);
    for (int w = 1; w <= 4; w++) begin
      #1 chkv($sformatf("to2_wait%0d", w), ifc.stall_timeout, (w == 4) ? 1 : 0);
      @(negedge clk);
    end
    din(F, 6'b0, 4'b0, F, 6'b010000);
    #1 chkv("to2_retire", ifc.retire_vld, 1);
    @(negedge clk);

    // Flush together with done in WAIT: no retire, next accept goes through.
    din(T, 6'b000010, 4'b0, F, 6'b0); #1; @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b0); #1; @(negedge clk);
    din(T, 6'b000001, 4'b0, T, 6'b000010);
    #1 chkv("fd_retire", ifc.retire_vld, 0);
    chkv("fd_ready", ifc.dec_ready, 0);
    @(negedge clk);
    din(T, 6'b000001, 4'b0, F, 6'b0);
    #1 chkv("fd_idle_ready", ifc.dec_ready, 1);
    chkv("fd_idle_stall", ifc.ex_stall, 0);
    @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b000001);
    #1 chkv("fd_next_sel", ifc.ex_unit_sel, 6'b000001);
    chkv("fd_next_ret", ifc.retire_vld, 1);
    @(negedge clk);

    // Flush in EXEC with done: select and retire suppressed.
    din(T, 6'b000100, 4'b0, F, 6'b0); #1; @(negedge clk);
    din(F, 6'b0, 4'b0, T, 6'b000100);
    #1 chkv("fe_sel", ifc.ex_unit_sel, 0);
    chkv("fe_ret", ifc.retire_vld, 0);
    @(negedge clk);

    // Reset during WAIT: nothing pending afterwards.
    din(T, 6'b100000, 4'b0, F, 6'b0); #1; @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b0); #1; @(negedge clk);
    rst = 1'b1; #1; @(negedge clk);
    rst = 1'b0;
    #1 chk_out("rst_wait", idle_o(5'd10));
    @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b100000);
    #1 chkv("rst_wait_noret", ifc.retire_vld, 0);
    @(negedge clk);

    // Reset during EXPT: no exception afterwards, vector back to 10.
    din(T, 6'b000001, 4'b1000, F, 6'b0); #1; @(negedge clk);
    din(F, 6'b0, 4'b0, F, 6'b0);
    rst = 1'b1; #1; @(negedge clk);
    rst = 1'b0;
    #1 chk_out("rst_expt", idle_o(5'd10));
    @(negedge clk);
    #1 chkv("rst_expt_later", ifc.expt_vld, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cr_iu_ex_ctrl_pipe.md
# cr_iu_ex_ctrl_pipe

Parametrised, registered execution-stage controller for the IU: it holds one decoded instruction in an EX slot and issues it to one of `UNIT_NUM` execution units. It supports multi-cycle units, tracks completion and retires the instruction. It also prioritises and emits exceptions and raises a stall-timeout flag. It sits between the IFU/decode output and the execution units (ALU, MAD, LSU, CP0, branch, special), and replaces purely combinational unit selection with a handshaked, stateful slot.

## Interface
Parameters:
- `UNIT_NUM`, 6: number of execution units; one-hot select width.
- `STALL_LIMIT`, 255: consecutive wait cycles before timeout; counter width is `$clog2(STALL_LIMIT+1)`.
- `VEC_W`, 5: exception vector width.

Ports:
- `forever_cpuclk`  in  1  sole clock.
- `cpurst`  in  1  synchronous, active-high reset.
- `dec_vld`  in  1  decoded instruction offered.
- `dec_ready`  out  1  slot accepts this cycle.
- `dec_unit_onehot`  in  UNIT_NUM  target unit; exactly one bit is set, and zero is legal only if `dec_rand`.
- `dec_rand`  in  1  random (datapath-only) instruction.
- `dec_ni`  in  1  non-interruptible instruction.
- `dec_expt_acc`, `dec_expt_inv`, `dec_expt_bkpt`, `dec_expt_ecall`  in  1 each  exception causes.
- `cp0_yy_priv_mode`  in  2  privilege at accept time.
- `wb_stall`  in  1  write buffer busy; blocks accept.
- `flush`  in  1  pipeline kill from CP0/branch.
- `unit_done`  in  UNIT_NUM  per-unit completion.
- `ex_unit_sel`  out  UNIT_NUM  control select, one-cycle pulse.
- `ex_data_sel`  out  UNIT_NUM  datapath select, level.
- `ex_stall`  out  1  slot occupied and not retiring.
- `retire_vld`  out  1  retire pulse.
- `retire_ni`  out  1  retire of an NI instruction.
- `expt_vld`  out  1  exception pulse.
- `expt_vec`  out  VEC_W  exception cause.
- `stall_timeout`  out  1  one-cycle pulse on reaching `STALL_LIMIT`.

## Operation
- FSM states: `IDLE`, `EXEC`, `WAIT`, `EXPT`. Reset puts the FSM in `IDLE`, clears all slot registers and the counter, and drives all outputs to 0. `expt_vec` resets to `5'd10`.
- Accept rule: `dec_ready = !flush && !wb_stall && (IDLE || retire_vld)`. On `dec_vld && dec_ready` the slot latches unit, rand, ni and the encoded vector, and the next state is `EXPT` if any cause is set, otherwise `EXEC`.
- Vector encoding is computed at accept time, in this priority order:
  - access = 1
  - inv = 2
  - bkpt = 3
  - ecall = 11 (M), 8 (U), 9 (S)
  - otherwise 10
- `EXEC`: `ex_unit_sel = slot_unit` (forced to 0 if `slot_rand`).
  - If `slot_rand`, or `unit_done & slot_unit` is non-zero, the instruction retires this cycle.
  - Otherwise the FSM moves to `WAIT`.
- `WAIT`: retires when `|(unit_done & slot_unit)`. Done bits from non-selected units are ignored.
- Retire: assert `retire_vld` and `retire_ni = slot_ni`. The next state is `EXEC`/`EXPT` if a new instruction is accepted in the same cycle, otherwise `IDLE`.
- `EXPT`: drive `expt_vld = 1` with the latched vector for one cycle, then go to `IDLE`. `dec_ready = 0` in this state. There is no retire and no unit select.
- `ex_data_sel = slot_unit` while in `EXEC`/`WAIT` (all zeros when rand).
- `ex_stall = (EXEC|WAIT) && !retire_vld`, or state is `EXPT`.
- Flush has the highest priority: next state is `IDLE`. In the same cycle `retire_vld`, `expt_vld`, `ex_unit_sel`, `stall_timeout` and `dec_ready` are all suppressed.
- Stall counter:
  - Increments in each `WAIT` cycle without done and saturates at `STALL_LIMIT`.
  - `stall_timeout` pulses only on the transition to `STALL_LIMIT`.
  - Clears on retire, flush or reset.

## Timing
- Accept in cycle t gives `EXEC` in t+1. A single-cycle unit retires in t+1, and back-to-back accepts give one instruction per cycle.
- An exception accepted at t produces `expt_vld` at t+1. The earliest next accept is t+2.
- A unit with completion latency L (L ≥ 1) retires at t+L.
- `cpurst` asserted during `WAIT` or `EXPT` suppresses outputs the next cycle. There is no pending exception or retire afterwards.

## Structure
- Shared package `cr_iu_pkg` holds:
  - state encoding (2-bit)
  - vector constants `EXPT_ACC=1`, `INV=2`, `BKPT=3`, `ECALL_U=8`, `ECALL_S=9`, `NONE=10`, `ECALL_M=11`
  - privilege constants
- Sub-module `cr_iu_expt_prio`: combinational cause-to-vector encoder, reused by future EX variants.

## Test plan
- `UNIT_NUM=6`, `dec_unit=6'b000001` with `unit_done` tied high every cycle, 4 consecutive instructions → `retire_vld` high 4 consecutive cycles, `ex_unit_sel=000001` each cycle.
- Unit 3, done after 5 cycles, while unit 0 pulses done at cycle 2 → retire exactly at accept+5, with `ex_stall` high for 4 cycles.
- `dec_expt_ecall` with priv=`2'b11`, plus `dec_expt_bkpt` set → `expt_vld` at t+1 with vector 3; `dec_ready=0` at t+1.
- `STALL_LIMIT=4`, no done → `stall_timeout` single pulse on the 4th `WAIT` cycle. The counter holds at 4 and clears on flush.
- `flush` in the same cycle as `unit_done` → no `retire_vld`, state `IDLE`. A following `dec_vld` is accepted the next cycle.
- `dec_rand` with `dec_ni` → `ex_unit_sel=0`, `retire_vld=retire_ni=1` at t+1.
